encoder_8x3_scan: RTL and testbench

//   Sequential 8-to-3 priority encoder: the encode-side counterpart of the 3x8 decoder.
//   - Latches one-hot/multi-hot request lines into a pending register.
//   - Emits the binary index of each pending bit, highest index first, one per handshake.
//   - Sits between request sources (interrupts, decoder-selected lines) and a consumer.

---
 rtl/encoder_8x3_scan.sv | 108 ++++++++++
 tb/tb_encoder_8x3_scan.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8x3_scan.sv
// Sequential 8-to-3 priority encoder that latches requests and emits their indices, highest first, one per accepted handshake.
// Latency: one cycle from req_load to idx_valid when idle; backpressure: idx_out and idx_valid hold while idx_ready is low.
module encoder_8x3_scan #(
    parameter int N_IN  = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  req_in,
    input  logic             req_load,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic             busy,
    output logic             ovr,
    input  logic             ovr_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N_IN-1:0]  pend;
    logic [N_IN-1:0]  pend_next;
    logic [N_IN-1:0]  served;
    logic [N_IN-1:0]  load;
    logic [IDX_W-1:0] idx_next;
    logic             ovr_next;
    logic             transfer;

    // Index of the highest set bit; an empty vector maps to index 0.
    function automatic logic [IDX_W-1:0] prio(input logic [N_IN-1:0] v);
        logic [IDX_W-1:0] p;
        p = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (v[i]) begin
                p = IDX_W'(i);
            end
        end
        return p;
    endfunction

    assign idx_valid = (state == OFFER);
    assign transfer  = idx_valid & idx_ready;
    assign busy      = |pend;

    always_comb begin
        served = '0;
        if (transfer) begin
            served[idx_out] = 1'b1;
        end
        load      = req_load ? req_in : '0;
        pend_next = (pend & ~served) | load;
    end

    // A bit that is reloaded in the same edge it is served is not a lost request.
    always_comb begin
        ovr_next = ovr;
        if (|(load & pend & ~served)) begin
            ovr_next = 1'b1;
        end else if (ovr_clr) begin
            ovr_next = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx_out;
        case (state)
            IDLE: begin
                if (|pend_next) begin
                    state_next = OFFER;
                    idx_next   = prio(pend_next);
                end
            end
            OFFER: begin
                if (idx_ready) begin
                    if (|pend_next) begin
                        idx_next = prio(pend_next);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pend    <= '0;
            idx_out <= '0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_next;
            pend    <= pend_next;
            idx_out <= idx_next;
            ovr     <= ovr_next;
        end
    end

endmodule

// File: tb/tb_encoder_8x3_scan.sv
// Scoreboard bench for encoder_8x3_scan: a pending-set model predicts each accepted index.
module tb_encoder_8x3_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic       req_load;
    logic [2:0] idx_out;
    logic       idx_valid;
    logic       idx_ready;
    logic       busy;
    logic       ovr;
    logic       ovr_clr;

    encoder_8x3_scan dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .req_load  (req_load),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .busy      (busy),
        .ovr       (ovr),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int seen[$];

    bit [7:0] mp;
    bit       mv;
    int       midx;
    bit       movr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hi_bit(input bit [7:0] v);
        int r = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = i;
                break;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        mp = 8'h00;
        mv = 1'b0;
        midx = 0;
        movr = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every handshake the DUT presents must match the next predicted index.
    always begin
        @(negedge clk);
        #2;
        if (!rst && idx_valid && idx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_extra: got idx %0d expected no output", idx_out);
            end else begin
                check("scoreboard_idx", idx_out, exp_q.pop_front());
            end
            seen.push_back(idx_out);
        end
    end

    // Called at a falling edge: drives one cycle of inputs, advances the model, checks state.
    task automatic cycle(input bit ld, input bit [7:0] rq, input bit rdy, input bit clr);
        bit [7:0] srv;
        bit [7:0] lv;
        bit [7:0] pn;
        req_load = ld;
        req_in = rq;
        idx_ready = rdy;
        ovr_clr = clr;
        srv = 8'h00;
        if (mv && rdy) begin
            exp_q.push_back(midx);
            srv[midx] = 1'b1;
        end
        lv = ld ? rq : 8'h00;
        pn = (mp & ~srv) | lv;
        if ((lv & mp & ~srv) != 8'h00) movr = 1'b1;
        else if (clr) movr = 1'b0;
        if (!mv) begin
            if (pn != 8'h00) begin
                mv = 1'b1;
                midx = hi_bit(pn);
            end
        end else if (rdy) begin
            if (pn != 8'h00) midx = hi_bit(pn);
            else mv = 1'b0;
        end
        mp = pn;
        @(posedge clk);
        #1;
        check("idx_valid", idx_valid, mv);
        check("busy", busy, (mp != 8'h00));
        check("ovr", ovr, movr);
        check("idx_out", idx_out, midx);
        @(negedge clk);
    endtask

    task automatic check_seen(input string name, input int exp[$]);
        check({name, "_count"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
            check(name, seen[i], exp[i]);
        end
        seen.delete();
    endtask

    initial begin
        int e[$];
        rst = 1'b1;
        req_in = 8'h00;
        req_load = 1'b0;
        idx_ready = 1'b0;
        ovr_clr = 1'b0;
        model_reset();
        #12;
        check("rst_idx_valid", idx_valid, 0);
        check("rst_idx_out", idx_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Multi-hot load drains highest index first.
        cycle(1, 8'hA4, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
        check("t1_valid_after", idx_valid, 0);
        check("t1_busy_after", busy, 0);
        e = '{7, 5, 2};
        check_seen("t1_seq", e);

        // Full vector at one index per cycle.
        cycle(1, 8'hFF, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0);
        check("t2_valid_drop", idx_valid, 0);
        e = '{7, 6, 5, 4, 3, 2, 1, 0};
        check_seen("t2_seq", e);

        // Stalled offer is not pre-empted by a higher-priority load.
        cycle(1, 8'h01, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h80, 0, 0);
        check("t3_held_idx", idx_out, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        e = '{0, 7};
        check_seen("t3_seq", e);

        // Overrun on a pending bit, clear, then serve-and-reload in one edge.
        cycle(1, 8'h08, 0, 0);
        cycle(1, 8'h08, 0, 0);
        check("t4_ovr_set", ovr, 1);
        cycle(0, 8'h00, 0, 1);
        check("t4_ovr_clr", ovr, 0);
        cycle(1, 8'h08, 1, 0);
        check("t4_no_ovr_reload", ovr, 0);
        cycle(0, 8'h00, 1, 0);
        e = '{3, 3};
        check_seen("t4_seq", e);

        // Empty load has no effect.
        cycle(1, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'h00, 1, 0);
            check("t5_valid", idx_valid, 0);
        end

        // Asynchronous reset mid-offer discards everything.
        cycle(1, 8'hA5, 0, 0);
        cycle(0, 8'h00, 0, 0);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_valid", idx_valid, 0);
        check("t6_rst_idx", idx_out, 0);
        check("t6_rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0);
        seen.delete();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            cycle(($urandom_range(0, 3) == 0), r, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 12; i++) cycle(0, 8'h00, 1, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
